nios2_proc_sample_logger: RTL and testbench
===========================================

Name: nios2_proc_sample_logger

Overview:
- Upstream feeder for the on-chip program/data RAM: captures a 32-bit sample stream from the BLDC sensing path (hall state, current ADC word, speed count) and writes it as consecutive words into the RAM through its second Avalon-MM slave.
- Nios II configures and arms it through a small CSR slave.
- On completion it raises an interrupt, and firmware reads the buffer from RAM.

Parameters:
- FIFO_DEPTH, 8, entries in the internal sample FIFO; power of two, 4..64.
- RAM_WORDS, 10360, number of valid 32-bit words in the target RAM; the write address wraps here.
- ADDR_W, 14, width of the word address driven to the RAM.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- snk_valid  in  1  sample stream valid.
- snk_data  in  32  sample word.
- snk_ready  out  1  sample stream ready.
- m_address  out  ADDR_W  RAM word address.
- m_chipselect  out  1  RAM select.
- m_write  out  1  RAM write strobe.
- m_byteenable  out  4  always 4'hF.
- m_writedata  out  32  word to RAM.
- m_waitrequest  in  1  slave stall; tie 0 for the plain RAM.
- csr_address  in  2  register select.
- csr_chipselect  in  1  CSR select.
- csr_write  in  1  CSR write.
- csr_read  in  1  CSR read.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, registered.
- irq  out  1  level interrupt.

Behaviour:
- Reset (reset_n low at a clk edge) clears the following:
  - State goes to IDLE; FIFO is emptied.
  - Registers: BASE=0, LENGTH=0, count=0, done=0, aborted=0, irq_en=0.
  - Outputs: snk_ready=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0, csr_readdata=0, irq=0.
- Reset mid-RUN abandons the transfer with no further RAM writes.
- CSR map (word addresses); writes take effect on the next edge:
  - 0 CTRL:
    - bit0 START: write 1 to start; ignored unless IDLE.
    - bit1 IRQ_EN: read/write.
    - bit2 ABORT: write 1 to abort; ignored in IDLE.
  - 1 BASE[ADDR_W-1:0]: start word address. Writes are ignored while busy.
  - 2 LENGTH[ADDR_W-1:0]: words to log. Writes are ignored while busy.
  - 3 STATUS, read-only except done:
    - bit0 busy.
    - bit1 done, sticky; write 1 to clear.
    - bit2 aborted, sticky; write 1 to clear.
    - bits[29:16] count.
- csr_readdata is valid the cycle after csr_read & csr_chipselect. Unused bits read 0.
- irq = IRQ_EN & done, combinational from registers.
- State machine:
  - IDLE: START with LENGTH=0 → set done, stay IDLE. START with LENGTH>0 → load address=BASE, count=0, clear done and aborted, go RUN.
  - RUN: snk_ready = ~fifo_full. A sample is pushed when snk_valid & snk_ready. Samples beyond LENGTH are not accepted: snk_ready=0 once pushed-count reaches LENGTH.
  - RUN writes: m_chipselect=m_write=1 whenever the FIFO is non-empty, with m_writedata = FIFO head. The word is retired (pop, count+1, address advance) on a cycle with m_write & ~m_waitrequest.
  - RUN completion: when count reaches LENGTH → set done, go IDLE.
  - ABORT in RUN: flush the FIFO, set aborted, leave done at 0, deassert m_write the next cycle, go IDLE.
- In IDLE: snk_ready=0 (upstream is back-pressured), and m_write=0.
- Address advance: next = (address == RAM_WORDS-1) ? 0 : address+1. A BASE ≥ RAM_WORDS is clamped to 0 on START.
- FIFO behaviour:
  - Simultaneous push and pop keeps the occupancy unchanged.
  - A push to a full FIFO cannot occur because snk_ready gates it.
  - A pop from an empty FIFO cannot occur because m_write gates it.
  - Latency from an accepted sample to m_write asserted is 1 cycle when the FIFO was empty.
- m_writedata and m_address hold stable while m_waitrequest=1.
- A CSR write of done-clear in the same cycle as hardware setting done leaves done set.

Test Plan:
- Basic log: BASE=100, LENGTH=4, START; stream 0xA0..0xA3 one per cycle, waitrequest=0 → RAM words 100..103 = 0xA0..0xA3; done=1 within 6 cycles of the last sample; irq=1 if IRQ_EN; STATUS count=4.
- Wrap: BASE=10358, LENGTH=4 → writes land at 10358, 10359, 0, 1 in order.
- Backpressure: hold m_waitrequest=1 for 20 cycles with LENGTH=16 and continuous valid → snk_ready drops after 8 (FIFO_DEPTH) accepts; no data lost; all 16 words are correct after release.
- Length and overrun: LENGTH=0 START → done immediately with no m_write. LENGTH=3 with 5 samples offered → exactly 3 accepted, and snk_ready=0 afterwards.
- Abort: LENGTH=100; after 10 writes assert ABORT → m_write is 0 the next cycle; aborted=1, done=0, busy=0; a subsequent START works from the new BASE.
- Reset: reset_n low for 1 cycle mid-RUN → all outputs and CSRs read their reset values; no RAM write follows.

Source files
------------

// File: rtl/nios2_proc_sample_logger.sv
// Sample stream logger: buffers a 32-bit sample stream in a small FIFO and
// writes it as consecutive words into on-chip RAM, configured through a CSR slave.
module nios2_proc_sample_logger #(
    parameter int FIFO_DEPTH = 8,
    parameter int RAM_WORDS  = 10360,
    parameter int ADDR_W     = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              snk_valid,
    input  logic [31:0]       snk_data,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic              m_waitrequest,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_WORDS - 1);
    localparam logic [PW:0] FULL_OCC = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] length_q, length_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] pushed_q, pushed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              irq_en_q, irq_en_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       occ_q, occ_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic csr_wr, csr_rd;
    logic wr_ctrl, wr_base, wr_len, wr_stat;
    logic start, abort, busy;
    logic fifo_empty, fifo_full;
    logic push, pop, last;
    logic unused_wdata;

    assign csr_wr     = csr_chipselect & csr_write;
    assign csr_rd     = csr_chipselect & csr_read;
    assign wr_ctrl    = csr_wr & (csr_address == 2'd0);
    assign wr_base    = csr_wr & (csr_address == 2'd1);
    assign wr_len     = csr_wr & (csr_address == 2'd2);
    assign wr_stat    = csr_wr & (csr_address == 2'd3);
    assign start      = wr_ctrl & csr_writedata[0];
    assign abort      = wr_ctrl & csr_writedata[2];
    assign busy       = (state_q == RUN);
    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == FULL_OCC);
    assign push       = snk_valid & snk_ready;
    assign pop        = m_write & ~m_waitrequest;
    assign last       = pop & ((count_q + 1'b1) == length_q);

    assign unused_wdata = ^csr_writedata[31:ADDR_W];
    assign csr_readdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            length_q  <= '0;
            count_q   <= '0;
            pushed_q  <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_en_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            length_q  <= length_d;
            count_q   <= count_d;
            pushed_q  <= pushed_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            irq_en_q  <= irq_en_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= snk_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && length_q != '0) state_d = RUN;
            RUN:  if (abort || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d    = base_q;
        length_d  = length_q;
        count_d   = count_q;
        pushed_d  = pushed_q;
        addr_d    = addr_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        irq_en_d  = irq_en_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rdata_d   = rdata_q;

        if (wr_ctrl) irq_en_d = csr_writedata[1];
        if (wr_base && !busy) base_d = csr_writedata[ADDR_W-1:0];
        if (wr_len && !busy) length_d = csr_writedata[ADDR_W-1:0];
        if (wr_stat && csr_writedata[1]) done_d = 1'b0;
        if (wr_stat && csr_writedata[2]) aborted_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            pushed_d = pushed_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
        occ_d = occ_q + (PW + 1)'(push) - (PW + 1)'(pop);

        // Hardware set of done is evaluated last so it beats a same-cycle clear
        if (!busy && start) begin
            if (length_q == '0) begin
                done_d = 1'b1;
            end else begin
                addr_d    = (base_q > LAST_ADDR) ? '0 : base_q;
                count_d   = '0;
                pushed_d  = '0;
                done_d    = 1'b0;
                aborted_d = 1'b0;
            end
        end
        if (busy && abort) begin
            aborted_d = 1'b1;
            occ_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else if (last) begin
            done_d = 1'b1;
        end

        if (csr_rd) begin
            rdata_d = '0;
            unique case (csr_address)
                2'd0: rdata_d[1] = irq_en_q;
                2'd1: rdata_d[ADDR_W-1:0] = base_q;
                2'd2: rdata_d[ADDR_W-1:0] = length_q;
                2'd3: begin
                    rdata_d[0]           = busy;
                    rdata_d[1]           = done_q;
                    rdata_d[2]           = aborted_q;
                    rdata_d[16 +: ADDR_W] = count_q;
                end
            endcase
        end
    end

    always_comb begin
        snk_ready    = busy & ~fifo_full & (pushed_q != length_q);
        m_write      = busy & ~fifo_empty;
        m_chipselect = m_write;
        m_byteenable = 4'hF;
        m_address    = addr_q;
        m_writedata  = m_write ? mem_q[rd_ptr_q] : '0;
        irq          = irq_en_q & done_q;
    end
endmodule

// File: tb/tb_nios2_proc_sample_logger.sv
// Directed and randomized bench for the sample logger; expected RAM contents
// come from a simple model: the first LENGTH offered samples at BASE, BASE+1, ...
module tb_nios2_proc_sample_logger;
    localparam int FIFO_DEPTH = 8;
    localparam int RAM_WORDS  = 10360;
    localparam int ADDR_W     = 14;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              snk_valid;
    logic [31:0]       snk_data;
    logic              snk_ready;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic              m_waitrequest;
    logic [1:0]        csr_address;
    logic              csr_chipselect;
    logic              csr_write;
    logic              csr_read;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;
    logic              irq;

    nios2_proc_sample_logger #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .RAM_WORDS(RAM_WORDS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .snk_valid(snk_valid),
        .snk_data(snk_data),
        .snk_ready(snk_ready),
        .m_address(m_address),
        .m_chipselect(m_chipselect),
        .m_write(m_write),
        .m_byteenable(m_byteenable),
        .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest),
        .csr_address(csr_address),
        .csr_chipselect(csr_chipselect),
        .csr_write(csr_write),
        .csr_read(csr_read),
        .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepts = 0;
    int last_acc = 0;
    int src_idx = 0;
    bit src_on = 0;
    bit force_wait = 0;
    int gap_pct = 0;
    int wait_pct = 0;
    logic [31:0] src[$];
    logic [ADDR_W-1:0] wa[$];
    logic [31:0] wd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records what the upcoming edge will do, then drives new inputs on the falling edge
    task automatic tick();
        if (snk_valid === 1'b1 && snk_ready === 1'b1) begin
            accepts++;
            src_idx++;
            last_acc = cyc;
        end
        if (m_chipselect === 1'b1 && m_write === 1'b1 && !m_waitrequest) begin
            wa.push_back(m_address);
            wd.push_back(m_writedata);
        end
        @(negedge clk);
        cyc++;
        snk_valid = src_on && (src_idx < src.size()) &&
                    ($urandom_range(99) >= gap_pct);
        snk_data = snk_valid ? src[src_idx] : 32'h0;
        m_waitrequest = force_wait || ($urandom_range(99) < wait_pct);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_chipselect = 1'b1;
        csr_write = 1'b1;
        csr_address = a;
        csr_writedata = d;
        tick();
        csr_chipselect = 1'b0;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_chipselect = 1'b1;
        csr_read = 1'b1;
        csr_address = a;
        tick();
        csr_chipselect = 1'b0;
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic fill(input int n);
        src.delete();
        repeat (n) src.push_back($urandom);
    endtask

    task automatic start_log(input int b, input int l);
        wa.delete();
        wd.delete();
        accepts = 0;
        src_idx = 0;
        src_on = 1;
        csr_wr(2'd1, 32'(b));
        csr_wr(2'd2, 32'(l));
        csr_wr(2'd0, 32'h3);
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("irq_done", 32'(irq), 32'h1);
    endtask

    task automatic verify(input int b, input int l);
        int eb = (b >= RAM_WORDS) ? 0 : b;
        int n = (wa.size() < l) ? wa.size() : l;
        chk("num_writes", wa.size(), l);
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", 32'(wa[i]), 32'((eb + i) % RAM_WORDS));
            chk("wr_data", wd[i], src[i]);
        end
    endtask

    task automatic check_done_status(input int l);
        logic [31:0] v;
        csr_rd(2'd3, v);
        chk("status_done", v, (32'(l) << 16) | 32'h2);
        csr_wr(2'd3, 32'h2);
        chk("irq_cleared", 32'(irq), 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        int n0;
        int a0;
        int b;
        int l;

        reset_n = 1'b0;
        snk_valid = 1'b0;
        snk_data = 32'h0;
        m_waitrequest = 1'b0;
        csr_address = 2'd0;
        csr_chipselect = 1'b0;
        csr_write = 1'b0;
        csr_read = 1'b0;
        csr_writedata = 32'h0;
        repeat (3) tick();
        reset_n = 1'b1;

        chk("rst_snk_ready", 32'(snk_ready), 32'h0);
        chk("rst_m_write", 32'(m_write), 32'h0);
        chk("rst_m_cs", 32'(m_chipselect), 32'h0);
        chk("rst_m_addr", 32'(m_address), 32'h0);
        chk("rst_readdata", csr_readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        csr_rd(2'd3, v);
        chk("rst_status", v, 32'h0);

        // Basic log, one sample per cycle
        src.delete();
        for (int i = 0; i < 4; i++) src.push_back(32'hA0 + 32'(i));
        start_log(100, 4);
        wait_irq(100);
        chk("done_latency_ok", 32'((cyc - last_acc) <= 6), 32'h1);
        chk("accepts_basic", accepts, 4);
        verify(100, 4);
        check_done_status(4);

        // Address wrap at the end of RAM
        fill(4);
        start_log(RAM_WORDS - 2, 4);
        wait_irq(100);
        verify(RAM_WORDS - 2, 4);
        check_done_status(4);

        // Backpressure from the RAM fills the FIFO
        fill(16);
        force_wait = 1;
        start_log(300, 16);
        repeat (20) tick();
        chk("bp_accepts", accepts, FIFO_DEPTH);
        chk("bp_ready_low", 32'(snk_ready), 32'h0);
        chk("bp_no_writes", wa.size(), 0);
        force_wait = 0;
        wait_irq(200);
        verify(300, 16);
        check_done_status(16);

        // LENGTH=0 completes at once without writes
        wa.delete();
        csr_wr(2'd2, 32'h0);
        csr_wr(2'd0, 32'h3);
        chk("len0_irq", 32'(irq), 32'h1);
        repeat (3) tick();
        chk("len0_no_writes", wa.size(), 0);
        csr_rd(2'd3, v);
        chk("len0_flags", v & 32'h7, 32'h2);
        csr_wr(2'd3, 32'h2);

        // Overrun: only LENGTH samples accepted
        fill(5);
        start_log(400, 3);
        wait_irq(100);
        repeat (5) tick();
        chk("overrun_accepts", accepts, 3);
        chk("overrun_ready", 32'(snk_ready), 32'h0);
        verify(400, 3);
        check_done_status(3);

        // Randomized runs with gaps, stalls and out-of-range BASE
        gap_pct = 30;
        wait_pct = 30;
        for (int k = 0; k < 8; k++) begin
            unique case (k % 3)
                0: b = $urandom_range(RAM_WORDS - 1);
                1: b = RAM_WORDS - 3;
                default: b = RAM_WORDS + $urandom_range(6000);
            endcase
            l = $urandom_range(20, 1);
            fill(l + $urandom_range(3));
            start_log(b, l);
            wait_irq(2000);
            repeat (5) tick();
            chk("rand_accepts", accepts, l);
            verify(b, l);
            check_done_status(l);
        end
        gap_pct = 0;
        wait_pct = 0;

        // Abort after ten words
        fill(100);
        start_log(50, 100);
        n0 = 0;
        while (wa.size() < 10 && n0 < 500) begin
            tick();
            n0++;
        end
        chk("abort_reached10", 32'(wa.size() >= 10), 32'h1);
        csr_wr(2'd0, 32'h6);
        chk("abort_mwrite", 32'(m_write), 32'h0);
        chk("abort_irq", 32'(irq), 32'h0);
        n0 = wa.size();
        for (int i = 0; i < n0; i++) begin
            chk("abort_addr", 32'(wa[i]), 32'(50 + i));
            chk("abort_data", wd[i], src[i]);
        end
        repeat (10) tick();
        chk("abort_no_more", wa.size(), n0);
        csr_rd(2'd3, v);
        chk("abort_flags", v & 32'h7, 32'h4);
        csr_wr(2'd3, 32'h4);
        fill(5);
        start_log(200, 5);
        wait_irq(100);
        verify(200, 5);
        check_done_status(5);

        // Reset in the middle of a run
        fill(50);
        start_log(500, 50);
        n0 = 0;
        while (wa.size() < 5 && n0 < 500) begin
            tick();
            n0++;
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mrst_snk_ready", 32'(snk_ready), 32'h0);
        chk("mrst_m_write", 32'(m_write), 32'h0);
        chk("mrst_m_cs", 32'(m_chipselect), 32'h0);
        chk("mrst_m_addr", 32'(m_address), 32'h0);
        chk("mrst_m_wdata", m_writedata, 32'h0);
        chk("mrst_readdata", csr_readdata, 32'h0);
        chk("mrst_irq", 32'(irq), 32'h0);
        n0 = wa.size();
        a0 = accepts;
        repeat (10) tick();
        chk("mrst_no_writes", wa.size(), n0);
        chk("mrst_no_accepts", accepts, a0);
        for (int r = 0; r < 4; r++) begin
            csr_rd(2'(r), v);
            chk("mrst_csr", v, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
